arbitro_op1: RTL and testbench
==============================

Name: arbitro_op1

Overview:
- Sequencer and arbiter for the shared 32-bit operand-1 path, which is a 2:1 mux selected by OP1_SRC.
- Two requesters compete for the path: requester 0 owns mux input Entrada1 and requester 1 owns Entrada2.
- The block grants the path to one requester, drives OP1_SRC, waits a configurable settle time, captures Mux_Out into a register and acknowledges the winner.
- Arbitration is round-robin.

Parameters:
- WIDTH, 32, data width of Mux_Out and Dato_Out.
- HOLD_CYCLES, 1, cycles OP1_SRC is held stable before capture; legal range 1..15.
- TIMEOUT, 8, max cycles in ESPERA_BAJA before error. Used only with MUX_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Req0  input  1  request from requester 0 (Entrada1 source).
- Req1  input  1  request from requester 1 (Entrada2 source).
- Mux_Out  input  WIDTH  output of the shared operand mux.
- OP1_SRC  output  1  mux select: 0 = Entrada1, 1 = Entrada2.
- Gnt0  output  1  grant to requester 0.
- Gnt1  output  1  grant to requester 1.
- Ack0  output  1  one-cycle capture-done pulse to requester 0.
- Ack1  output  1  one-cycle capture-done pulse to requester 1.
- Dato_Out  output  WIDTH  captured operand.
- Ocupado  output  1  high whenever state is not IDLE.
- Error  output  1  sticky timeout flag; tied 0 when the feature is absent.

Behaviour:
- Reset (asynchronous, any state): all outputs 0, Dato_Out = 0, state IDLE, hold counter 0, priority register Ultimo = 1. With Ultimo = 1, requester 0 wins the first tie.
- States: IDLE, SELECCION, CAPTURA, ESPERA_BAJA. All outputs are registered.
- IDLE, arbitration on edge k:
  - Only Req0 high: winner 0.
  - Only Req1 high: winner 1.
  - Both high: winner = ~Ultimo.
  - Neither high: stay in IDLE.
  - At edge k: OP1_SRC <= winner, Gnt[winner] <= 1, counter <= HOLD_CYCLES-1, go to SELECCION.
- SELECCION:
  - Counter nonzero: decrement.
  - Counter zero: go to CAPTURA.
  - OP1_SRC and Gnt are frozen; requests are ignored.
- CAPTURA (one cycle):
  - Dato_Out <= Mux_Out.
  - Ack[winner] <= 1 and Gnt[winner] <= 0 on the same edge.
  - Ultimo <= winner.
  - Go to ESPERA_BAJA.
- Latency: Ack[winner] and the new Dato_Out are visible after edge k+HOLD_CYCLES+1. Gnt is high for exactly HOLD_CYCLES+1 cycles.
- ESPERA_BAJA:
  - Ack[winner] <= 0, so Ack is exactly one cycle wide.
  - Remain until Req[winner] is sampled low, then go to IDLE.
  - The loser's request stays pending and is not lost.
- Back-to-back: a loser held high is granted on the first IDLE edge. Minimum spacing between consecutive grants is 1 IDLE cycle.
- Dato_Out holds its value until the next CAPTURA. OP1_SRC keeps its last value in IDLE.
- Req changes during SELECCION or CAPTURA have no effect, including the winner dropping its request. The transaction always completes.
- Reset during SELECCION or CAPTURA aborts the transaction: no Ack, Dato_Out = 0.
- Gnt0 and Gnt1 are never high together. Ack0 and Ack1 are never high together.

Optional Feature:
- Macro: MUX_ARB_TIMEOUT_EN.
- Defined: a counter runs in ESPERA_BAJA. If Req[winner] is still high after TIMEOUT cycles, the block sets Error <= 1 and goes to IDLE. Error stays set until reset. Arbitration continues normally with Ultimo already updated.
- Undefined: ESPERA_BAJA waits indefinitely, Error is constant 0, and the timeout counter is not synthesized.

Test Plan:
- Bench setup: mux model with Entrada1 = 2 and Entrada2 = 1.
- Reset then idle, Req0 = Req1 = 0 for 10 cycles -> all outputs 0, Ocupado = 0, Dato_Out = 0.
- Req0 pulsed high until Ack0, HOLD_CYCLES = 1 -> Gnt0 high 2 cycles, OP1_SRC = 0, Ack0 one cycle at edge k+2, Dato_Out = 2.
- Req0 and Req1 high together from reset, each dropped after its Ack -> requester 0 served first (Dato_Out = 2), then requester 1 (OP1_SRC = 1, Dato_Out = 1). Gnt0 and Gnt1 never overlap.
- Both requesters held high continuously, each re-requesting right after its Ack -> grants alternate 0,1,0,1 and Dato_Out alternates 2,1,2,1.
- Reset asserted during SELECCION with Req1 = 1 -> Gnt1 drops immediately, no Ack1, Dato_Out = 0. After release the request is re-arbitrated and completes with Dato_Out = 1.
- With MUX_ARB_TIMEOUT_EN and TIMEOUT = 8, Req0 held high after Ack0 -> Error = 1 after 8 cycles in ESPERA_BAJA, return to IDLE. Without the macro -> Ocupado stays 1 and Error = 0.

Source files
------------

// File: rtl/arbitro_op1.sv
// Round-robin sequencer/arbiter for the shared operand-1 mux: grant, hold OP1_SRC, capture, acknowledge.
// Optional ESPERA_BAJA timeout with sticky Error is enabled by defining MUX_ARB_TIMEOUT_EN.
module arbitro_op1 #(
   parameter int WIDTH       = 32,
   parameter int HOLD_CYCLES = 1,
   parameter int TIMEOUT     = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Req0,
   input  logic             Req1,
   input  logic [WIDTH-1:0] Mux_Out,
   output logic             OP1_SRC,
   output logic             Gnt0,
   output logic             Gnt1,
   output logic             Ack0,
   output logic             Ack1,
   output logic [WIDTH-1:0] Dato_Out,
   output logic             Ocupado,
   output logic             Error
);

   typedef enum logic [1:0] {IDLE, SELECCION, CAPTURA, ESPERA_BAJA} state_t;

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             src_q, src_d;
   logic             gnt0_q, gnt0_d;
   logic             gnt1_q, gnt1_d;
   logic             ack0_q, ack0_d;
   logic             ack1_q, ack1_d;
   logic [WIDTH-1:0] dato_q, dato_d;
   logic             ultimo_q, ultimo_d;
   logic             ocupado_q, ocupado_d;
   logic             win;
   logic             req_win;

   // OP1_SRC doubles as the identity of the current winner.
   assign req_win = src_q ? Req1 : Req0;

`ifdef MUX_ARB_TIMEOUT_EN
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          error_q, error_d;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      src_d    = src_q;
      gnt0_d   = gnt0_q;
      gnt1_d   = gnt1_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      dato_d   = dato_q;
      ultimo_d = ultimo_q;
      win      = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      tmo_d    = tmo_q;
      error_d  = error_q;
`endif
      case (state_q)
         IDLE: begin
            if (Req0 || Req1) begin
               win     = (Req0 && Req1) ? ~ultimo_q : Req1;
               src_d   = win;
               gnt0_d  = ~win;
               gnt1_d  = win;
               cnt_d   = 4'(HOLD_CYCLES - 1);
               state_d = SELECCION;
            end
         end
         SELECCION: begin
            if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
            else               state_d = CAPTURA;
         end
         CAPTURA: begin
            dato_d   = Mux_Out;
            ack0_d   = ~src_q;
            ack1_d   = src_q;
            gnt0_d   = 1'b0;
            gnt1_d   = 1'b0;
            ultimo_d = src_q;
            state_d  = ESPERA_BAJA;
`ifdef MUX_ARB_TIMEOUT_EN
            tmo_d    = '0;
`endif
         end
         ESPERA_BAJA: begin
            if (!req_win) begin
               state_d = IDLE;
            end
`ifdef MUX_ARB_TIMEOUT_EN
            else if (tmo_q == TW'(TIMEOUT - 1)) begin
               error_d = 1'b1;
               state_d = IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
      ocupado_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         src_q     <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         dato_q    <= '0;
         ultimo_q  <= 1'b1;
         ocupado_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         src_q     <= src_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         dato_q    <= dato_d;
         ultimo_q  <= ultimo_d;
         ocupado_q <= ocupado_d;
      end
   end

`ifdef MUX_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tmo_q   <= '0;
         error_q <= 1'b0;
      end else begin
         tmo_q   <= tmo_d;
         error_q <= error_d;
      end
   end
   assign Error = error_q;
`else
   assign Error = 1'b0;
`endif

   assign OP1_SRC  = src_q;
   assign Gnt0     = gnt0_q;
   assign Gnt1     = gnt1_q;
   assign Ack0     = ack0_q;
   assign Ack1     = ack1_q;
   assign Dato_Out = dato_q;
   assign Ocupado  = ocupado_q;

endmodule

// File: tb/tb_arbitro_op1.sv
// Directed bench for arbitro_op1: mux model Entrada1 = 2, Entrada2 = 1, HOLD_CYCLES = 1.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_arbitro_op1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0 = 1'b0;
   logic        req1 = 1'b0;
   logic [31:0] mux_out;
   logic        op1_src, gnt0, gnt1, ack0, ack1, ocupado, err;
   logic [31:0] dato;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   assign mux_out = op1_src ? 32'd1 : 32'd2;

   arbitro_op1 #(.WIDTH(32), .HOLD_CYCLES(1), .TIMEOUT(8)) dut (
      .clk(clk), .reset(rst), .Req0(req0), .Req1(req1), .Mux_Out(mux_out),
      .OP1_SRC(op1_src), .Gnt0(gnt0), .Gnt1(gnt1), .Ack0(ack0), .Ack1(ack1),
      .Dato_Out(dato), .Ocupado(ocupado), .Error(err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         chk("gnt_excl", {31'd0, gnt0 & gnt1}, 32'd0);
         chk("ack_excl", {31'd0, ack0 & ack1}, 32'd0);
      end
   end

   initial begin
      logic w;
      // reset and idle
      nxt(); nxt();
      chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      chk("rst_ocup", {31'd0, ocupado}, 32'd0);
      rst = 1'b0;
      repeat (10) nxt();
      chk("idle_outs", {26'd0, err, op1_src, ack1, ack0, gnt1, gnt0}, 32'd0);
      chk("idle_ocup", {31'd0, ocupado}, 32'd0);
      chk("idle_dato", dato, 32'd0);

      // single request from requester 0
      req0 = 1'b1;
      nxt();
      chk("r0_k_gnt", {30'd0, gnt1, gnt0}, 32'd1);
      chk("r0_k_src", {31'd0, op1_src}, 32'd0);
      chk("r0_k_ack", {30'd0, ack1, ack0}, 32'd0);
      chk("r0_k_ocup", {31'd0, ocupado}, 32'd1);
      nxt();
      chk("r0_k1_gnt", {30'd0, gnt1, gnt0}, 32'd1);
      chk("r0_k1_ack", {30'd0, ack1, ack0}, 32'd0);
      nxt();
      chk("r0_k2_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      chk("r0_k2_ack", {30'd0, ack1, ack0}, 32'd1);
      chk("r0_k2_dato", dato, 32'd2);
      req0 = 1'b0;
      nxt();
      chk("r0_k3_ack", {30'd0, ack1, ack0}, 32'd0);
      chk("r0_k3_ocup", {31'd0, ocupado}, 32'd0);
      chk("r0_k3_dato", dato, 32'd2);

      // tie straight after reset: requester 0 first, then 1
      rst = 1'b1;
      nxt();
      chk("rst2_dato", dato, 32'd0);
      rst = 1'b0;
      req0 = 1'b1;
      req1 = 1'b1;
      nxt();
      chk("tie_k_gnt", {30'd0, gnt1, gnt0}, 32'd1);
      nxt();
      nxt();
      chk("tie_k2_ack", {30'd0, ack1, ack0}, 32'd1);
      chk("tie_k2_dato", dato, 32'd2);
      req0 = 1'b0;
      nxt();
      chk("tie_k3_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      chk("tie_k3_ocup", {31'd0, ocupado}, 32'd0);
      nxt();
      chk("tie_k4_gnt", {30'd0, gnt1, gnt0}, 32'd2);
      chk("tie_k4_src", {31'd0, op1_src}, 32'd1);
      nxt();
      chk("tie_k5_gnt", {30'd0, gnt1, gnt0}, 32'd2);
      nxt();
      chk("tie_k6_ack", {30'd0, ack1, ack0}, 32'd2);
      chk("tie_k6_dato", dato, 32'd1);
      req1 = 1'b0;
      nxt();
      chk("tie_k7_ocup", {31'd0, ocupado}, 32'd0);

      // both held high, winner re-requests right after its Ack: 0,1,0,1
      req0 = 1'b1;
      req1 = 1'b1;
      for (int t = 0; t < 4; t++) begin
         w = t[0];
         nxt();
         chk("alt_gnt", {30'd0, gnt1, gnt0}, w ? 32'd2 : 32'd1);
         chk("alt_src", {31'd0, op1_src}, {31'd0, w});
         nxt();
         nxt();
         chk("alt_ack", {30'd0, ack1, ack0}, w ? 32'd2 : 32'd1);
         chk("alt_dato", dato, w ? 32'd1 : 32'd2);
         if (w) req1 = 1'b0; else req0 = 1'b0;
         nxt();
         chk("alt_ocup", {31'd0, ocupado}, 32'd0);
         if (w) req1 = 1'b1; else req0 = 1'b1;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      nxt();

      // reset during SELECCION aborts, request is then re-arbitrated
      req1 = 1'b1;
      nxt();
      chk("ab_gnt", {30'd0, gnt1, gnt0}, 32'd2);
      rst = 1'b1;
      #1;
      chk("ab_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
      chk("ab_rst_ack", {30'd0, ack1, ack0}, 32'd0);
      chk("ab_rst_dato", dato, 32'd0);
      nxt();
      chk("ab_hold_ack", {30'd0, ack1, ack0}, 32'd0);
      rst = 1'b0;
      nxt();
      chk("ab_re_gnt", {30'd0, gnt1, gnt0}, 32'd2);
      chk("ab_re_src", {31'd0, op1_src}, 32'd1);
      nxt();
      nxt();
      chk("ab_re_ack", {30'd0, ack1, ack0}, 32'd2);
      chk("ab_re_dato", dato, 32'd1);
      req1 = 1'b0;
      nxt();
      chk("ab_end_ocup", {31'd0, ocupado}, 32'd0);

      // requester 0 never releases after its Ack
      req0 = 1'b1;
      nxt();
      nxt();
      nxt();
      chk("to_ack", {30'd0, ack1, ack0}, 32'd1);
      repeat (7) nxt();
      chk("to_pre_err", {31'd0, err}, 32'd0);
      chk("to_pre_ocup", {31'd0, ocupado}, 32'd1);
      nxt();
`ifdef MUX_ARB_TIMEOUT_EN
      chk("to_err", {31'd0, err}, 32'd1);
      chk("to_ocup", {31'd0, ocupado}, 32'd0);
`else
      chk("to_err", {31'd0, err}, 32'd0);
      chk("to_ocup", {31'd0, ocupado}, 32'd1);
`endif
      req0 = 1'b0;
      repeat (4) nxt();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
